// File: rtl/irq_controller_pkg.sv
// Shared constants and types for the Peribus interrupt controller.
package irq_controller_pkg;

    // Peribus register slot map
    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    // STATUS register field positions (vector occupies the low VEC_W bits)
    localparam int unsigned STATUS_INSVC_BIT = 15;
    localparam int unsigned STATUS_IRQ_BIT   = 14;

    // CTRL register field positions
    localparam int unsigned CTRL_GLOBAL_EN_BIT = 0;

    // Controller handshake state
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } irqc_state_t;

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational fixed-priority encoder: the lowest set request index wins.
module irq_priority_encoder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 4
) (
    input  logic [WIDTH-1:0] req,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // Scan upward and latch the first set bit only
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (req[i] && !valid) begin
                valid = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Peribus interrupt controller: masks level irqs, picks the lowest-index
// active source and runs a single-level request/ack/EOI handshake with the CPU.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int unsigned NUM_SOURCES = 8,
    parameter int unsigned VEC_W       = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             addr,
    input  logic [15:0]            write_data,
    input  logic                   write_en,
    input  logic                   read_en,
    input  logic                   chipselect,
    output logic [15:0]            read_data,
    input  logic [NUM_SOURCES-1:0] irq_in,
    output logic                   cpu_irq,
    output logic [VEC_W-1:0]       cpu_vector,
    input  logic                   cpu_ack,
    input  logic                   cpu_eoi
);

    logic [NUM_SOURCES-1:0] enable_q, enable_d;
    logic                   ctrl_en_q, ctrl_en_d;
    irqc_state_t            state_q, state_d;
    logic                   cpu_irq_q, cpu_irq_d;
    logic [VEC_W-1:0]       cpu_vector_q, cpu_vector_d;
    logic [15:0]            read_data_q, read_data_d;

    logic [NUM_SOURCES-1:0] pending;
    logic                   any_pending;
    logic [VEC_W-1:0]       winner;
    logic                   valid;
    logic                   bus_wr;
    logic                   bus_rd;
    logic                   status_wr;
    logic                   eoi;
    logic [15:0]            rd_value;
    logic                   unused_wdata;

    assign pending   = irq_in & enable_q;
    assign valid     = any_pending && ctrl_en_q;
    assign bus_wr    = chipselect && write_en;
    assign bus_rd    = chipselect && read_en;
    assign status_wr = bus_wr && (addr == REG_STATUS);
    // A STATUS write and a cpu_eoi pulse in the same cycle collapse into one EOI
    assign eoi       = cpu_eoi || status_wr;

    // Only the low NUM_SOURCES bits / CTRL bit 0 are stored; the rest are ignored
    assign unused_wdata = ^write_data;

    irq_priority_encoder #(
        .WIDTH (NUM_SOURCES),
        .IDX_W (VEC_W)
    ) u_prio (
        .req   (pending),
        .valid (any_pending),
        .index (winner)
    );

    // Register read multiplexer; unimplemented bits read as zero
    always_comb begin
        rd_value = '0;
        case (addr)
            REG_ENABLE:  rd_value[NUM_SOURCES-1:0] = enable_q;
            REG_PENDING: rd_value[NUM_SOURCES-1:0] = pending;
            REG_STATUS: begin
                rd_value[STATUS_INSVC_BIT] = (state_q == SERVICE);
                rd_value[STATUS_IRQ_BIT]   = cpu_irq_q;
                rd_value[VEC_W-1:0]        = cpu_vector_q;
            end
            REG_CTRL:    rd_value[CTRL_GLOBAL_EN_BIT] = ctrl_en_q;
            default:     rd_value = '0;
        endcase
    end

    // Register writes and the registered read-data path
    always_comb begin
        enable_d    = enable_q;
        ctrl_en_d   = ctrl_en_q;
        read_data_d = read_data_q;
        if (bus_wr && (addr == REG_ENABLE)) begin
            enable_d = write_data[NUM_SOURCES-1:0];
        end
        if (bus_wr && (addr == REG_CTRL)) begin
            ctrl_en_d = write_data[CTRL_GLOBAL_EN_BIT];
        end
        if (bus_rd) begin
            read_data_d = rd_value;
        end
    end

    // Request/ack/EOI handshake; in REQUEST an ack wins over a same-cycle loss of valid
    always_comb begin
        state_d      = state_q;
        cpu_irq_d    = cpu_irq_q;
        cpu_vector_d = cpu_vector_q;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d      = REQUEST;
                    cpu_irq_d    = 1'b1;
                    cpu_vector_d = winner;
                end
            end
            REQUEST: begin
                if (cpu_ack) begin
                    state_d   = SERVICE;
                    cpu_irq_d = 1'b0;
                end else if (!valid) begin
                    state_d   = IDLE;
                    cpu_irq_d = 1'b0;
                end else begin
                    cpu_vector_d = winner;
                end
            end
            SERVICE: begin
                cpu_irq_d = 1'b0;
                if (eoi) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                cpu_irq_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clock) begin
        if (reset) begin
            enable_q     <= '0;
            ctrl_en_q    <= 1'b0;
            state_q      <= IDLE;
            cpu_irq_q    <= 1'b0;
            cpu_vector_q <= '0;
            read_data_q  <= '0;
        end else begin
            enable_q     <= enable_d;
            ctrl_en_q    <= ctrl_en_d;
            state_q      <= state_d;
            cpu_irq_q    <= cpu_irq_d;
            cpu_vector_q <= cpu_vector_d;
            read_data_q  <= read_data_d;
        end
    end

    assign read_data  = read_data_q;
    assign cpu_irq    = cpu_irq_q;
    assign cpu_vector = cpu_vector_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus random traffic
// compared every cycle against a behavioural model.
module tb_irq_controller;

    localparam int unsigned N  = 8;
    localparam int unsigned VW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    addr = '0;
    logic [15:0]   write_data = '0;
    logic          write_en = 1'b0;
    logic          read_en = 1'b0;
    logic          chipselect = 1'b0;
    logic [15:0]   read_data;
    logic [N-1:0]  irq_in = '0;
    logic          cpu_irq;
    logic [VW-1:0] cpu_vector;
    logic          cpu_ack = 1'b0;
    logic          cpu_eoi = 1'b0;

    int tests  = 0;
    int failed = 0;
    bit chk_en = 1'b0;

    irq_controller #(
        .NUM_SOURCES (N),
        .VEC_W       (VW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .addr       (addr),
        .write_data (write_data),
        .write_en   (write_en),
        .read_en    (read_en),
        .chipselect (chipselect),
        .read_data  (read_data),
        .irq_in     (irq_in),
        .cpu_irq    (cpu_irq),
        .cpu_vector (cpu_vector),
        .cpu_ack    (cpu_ack),
        .cpu_eoi    (cpu_eoi)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model tracks "is the CPU being asked" and "is an interrupt being serviced"
    logic          m_svc = 1'b0;
    logic          m_irq = 1'b0;
    logic [VW-1:0] m_vec = '0;
    logic [N-1:0]  m_en  = '0;
    logic          m_ctrl = 1'b0;
    logic [15:0]   m_rd  = '0;

    function automatic logic [VW-1:0] lowest(input logic [N-1:0] p);
        for (int i = 0; i < int'(N); i++) begin
            if (p[i]) return VW'(i);
        end
        return '0;
    endfunction

    logic [N-1:0]  m_pend;
    logic          m_valid;
    logic [VW-1:0] m_win;
    logic [15:0]   m_rdval;
    logic          m_wr, m_rdstb, m_eoi;

    always_comb begin
        m_pend  = irq_in & m_en;
        m_valid = (m_pend != '0) && m_ctrl;
        m_win   = lowest(m_pend);
        m_wr    = chipselect && write_en;
        m_rdstb = chipselect && read_en;
        m_eoi   = cpu_eoi || (m_wr && addr == 2'd2);
        case (addr)
            2'd0:    m_rdval = 16'(m_en);
            2'd1:    m_rdval = 16'(m_pend);
            2'd2:    m_rdval = {m_svc, m_irq, 10'd0, m_vec};
            default: m_rdval = {15'd0, m_ctrl};
        endcase
    end

    always @(posedge clock) begin
        if (reset) begin
            m_svc <= 1'b0; m_irq <= 1'b0; m_vec <= '0;
            m_en <= '0; m_ctrl <= 1'b0; m_rd <= '0;
        end else begin
            if (m_svc) begin
                if (m_eoi) m_svc <= 1'b0;
            end else if (m_irq) begin
                if (cpu_ack) begin
                    m_svc <= 1'b1; m_irq <= 1'b0;
                end else if (!m_valid) begin
                    m_irq <= 1'b0;
                end else begin
                    m_vec <= m_win;
                end
            end else if (m_valid) begin
                m_irq <= 1'b1; m_vec <= m_win;
            end
            if (m_wr && addr == 2'd0) m_en   <= write_data[N-1:0];
            if (m_wr && addr == 2'd3) m_ctrl <= write_data[0];
            if (m_rdstb) m_rd <= m_rdval;
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clock) begin
        if (chk_en) begin
            check("model_cpu_irq", 16'(cpu_irq), 16'(m_irq));
            check("model_cpu_vector", 16'(cpu_vector), 16'(m_vec));
            check("model_read_data", read_data, m_rd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [15:0] d);
        addr = a; write_data = d; chipselect = 1'b1; write_en = 1'b1;
        tick();
        chipselect = 1'b0; write_en = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [15:0] d);
        addr = a; chipselect = 1'b1; read_en = 1'b1;
        tick();
        chipselect = 1'b0; read_en = 1'b0;
        d = read_data;
    endtask

    logic [15:0] rv;
    logic [15:0] rnd;

    initial begin
        // Reset
        reset = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        check("reset_cpu_irq", 16'(cpu_irq), 16'h0);
        check("reset_cpu_vector", 16'(cpu_vector), 16'h0);
        check("reset_read_data", read_data, 16'h0);
        reset = 1'b0;

        // 1: basic request
        reg_write(2'd0, 16'h0005);
        reg_write(2'd3, 16'h0001);
        irq_in = 8'h04;
        tick();
        check("t1_cpu_irq", 16'(cpu_irq), 16'h1);
        check("t1_vector", 16'(cpu_vector), 16'h2);
        reg_read(2'd2, rv);
        check("t1_status", rv, 16'h4002);

        // 2: overtake by higher priority, then ack
        irq_in = 8'h05;
        tick();
        check("t2_vector_overtake", 16'(cpu_vector), 16'h0);
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
        check("t2_irq_after_ack", 16'(cpu_irq), 16'h0);
        reg_read(2'd2, rv);
        check("t2_status_svc", rv, 16'h8000);

        // 3: no nesting, EOI then one IDLE cycle then re-request
        tick();
        check("t3_no_nesting", 16'(cpu_irq), 16'h0);
        cpu_eoi = 1'b1;
        tick();
        cpu_eoi = 1'b0;
        check("t3_idle_cycle", 16'(cpu_irq), 16'h0);
        tick();
        check("t3_rerequest", 16'(cpu_irq), 16'h1);
        check("t3_rerequest_vec", 16'(cpu_vector), 16'h0);

        // 4: spurious withdrawal, late ack ignored
        irq_in = '0;
        tick();
        check("t4_withdraw", 16'(cpu_irq), 16'h0);
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
        reg_read(2'd2, rv);
        check("t4_status_after_ack", rv, 16'h0000);

        // 5: global disable gates the request; enabling raises it
        reg_write(2'd0, 16'h00FF);
        reg_write(2'd3, 16'h0000);
        irq_in = 8'hFF;
        reg_read(2'd1, rv);
        check("t5_pending", rv, 16'h00FF);
        tick();
        check("t5_gated", 16'(cpu_irq), 16'h0);
        reg_write(2'd3, 16'h0001);
        check("t5_ctrl_write_edge", 16'(cpu_irq), 16'h0);
        tick();
        check("t5_enabled_irq", 16'(cpu_irq), 16'h1);
        check("t5_enabled_vec", 16'(cpu_vector), 16'h0);

        // 6: reset wins over a simultaneous EOI
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
        cpu_eoi = 1'b1; reset = 1'b1;
        tick();
        cpu_eoi = 1'b0; reset = 1'b0;
        check("t6_irq", 16'(cpu_irq), 16'h0);
        check("t6_vec", 16'(cpu_vector), 16'h0);
        check("t6_rd", read_data, 16'h0);
        reg_read(2'd0, rv);
        check("t6_enable_cleared", rv, 16'h0000);
        tick();
        tick();
        check("t6_no_request", 16'(cpu_irq), 16'h0);

        // Random traffic against the model
        reg_write(2'd0, 16'h00FF);
        reg_write(2'd3, 16'h0001);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) irq_in = N'($urandom);
            cpu_ack = ($urandom_range(3) == 0);
            cpu_eoi = ($urandom_range(5) == 0);
            reset   = ($urandom_range(199) == 0);
            chipselect = 1'b0; write_en = 1'b0; read_en = 1'b0;
            if ($urandom_range(3) == 0) begin
                chipselect = ($urandom_range(7) != 0);
                addr = 2'($urandom);
                rnd = 16'($urandom);
                if (addr == 2'd3) rnd[0] = ($urandom_range(4) != 0);
                write_data = rnd;
                if ($urandom_range(1) == 0) write_en = 1'b1;
                else read_en = 1'b1;
            end
            tick();
        end
        cpu_ack = 1'b0; cpu_eoi = 1'b0; reset = 1'b0;
        chipselect = 1'b0; write_en = 1'b0; read_en = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
